muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, fed by the forwarded operand pair from the ALU operand-select logic. It runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a fixed multi-cycle latency. It raises a stall that freezes the pipeline while it works, and its result is muxed with the ALU result into EX/MEM.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; iteration count equals `XLEN`.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: active-low reset, asserted and cleared asynchronously.
- `start` input 1: EX holds a valid M-extension instruction; held high by the frozen pipeline until the op completes.
- `op` input 3: funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `opA` input XLEN: forwarded rs1 value.
- `opB` input XLEN: forwarded rs2 value, taken before the immediate select.
- `flush` input 1: kill any in-flight op (branch/exception).
- `stall` output 1: freeze PC/IF/ID/ID-EX.
- `busy` output 1: iteration in progress.
- `done` output 1: one-cycle pulse; `result` is valid in that cycle.
- `result` output XLEN: registered result, held until the next `done`.

## Operation
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- The FSM has three states: IDLE, BUSY, DONE. Reset gives IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
- IDLE to BUSY happens at an edge with `start`=1 and `flush`=0. At that edge the unit latches `op`, the sign flags, the operand magnitudes, and the special-case flags, and clears the counter.
- Sign handling:
  - `opA` is signed for MULH, MULHSU, DIV, REM.
  - `opB` is signed for MULH, DIV, REM.
  - MUL uses the same low 32 bits for either signedness.
  - The magnitude of 0x80000000 is 2^31, unsigned.
- Multiply uses shift-add over the 32 bits of the |B| magnitude into a 64-bit accumulator. The product is negated when the operand signs differ.
  - MUL returns product[31:0].
  - All MULH variants return product[63:32].
- Divide uses restoring shift-subtract for 32 iterations on the magnitudes.
  - Quotient is negated when the signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- Special cases are detected at latch time, run the full latency, and override the result at the edge into DONE:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give opA.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0.
- BUSY to DONE happens when counter=31 at the edge. At that edge `result` is written.
- DONE to IDLE is unconditional. `start` is ignored in DONE because it still belongs to the completing instruction.
- `flush`=1 at any edge in BUSY or DONE gives IDLE next: no `done`, `result` unchanged. `flush` has priority over `start`.
- Outputs:
  - `busy` = (state==BUSY).
  - `done` = (state==DONE).
  - `stall` = (state==IDLE && `start` && !`flush`) || state==BUSY, combinational.

## Timing
- The op is seen in cycle C0, with state IDLE and `start`=1.
- `stall` is high in C0 through C32 (33 cycles). It is low in C33.
- `busy` is high in C1 through C32.
- `done` and a valid `result` appear in C33. The pipeline advances at the end of C33, and EX/MEM captures `result`.
- Latency is 33 cycles for every op and operand value.
- Back-to-back M-ops: the next op is seen in C34, so `stall` goes high combinationally in C34 with no bubble beyond the DONE cycle.
- `rst_n` low mid-op: all state and outputs go to reset values immediately, without waiting for a clock edge. Operation resumes at the first edge after deassertion.
- Operand/op changes during BUSY have no effect, because they are latched at C0.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3): `result`=0xFFFFFFEB. `stall` high exactly 33 cycles, `done` pulses once in C33.
- Multiply high halves:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All complete in 33 cycles.
- Flush:
  - `flush` pulsed in C10 of a DIVU gives IDLE at the next edge, no `done`, `result` unchanged.
  - A new MUL 3×4 started afterwards gives 12 after 33 cycles.
- Reset and back-to-back:
  - `rst_n` low asynchronously in C20 gives `busy`/`done`/`stall`/`result`=0 before the next edge.
  - After release, two back-to-back ops with `start` held give `done` pulses 34 cycles apart and correct results.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide for the EX stage.
// Every op takes XLEN BUSY cycles plus one DONE cycle. Operands are reduced to
// magnitudes at launch and the signs are applied at the final edge.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Control state (reset applies here)
    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [XLEN-1:0]       r_result;

    // Datapath state, loaded at launch
    logic [2:0]            r_op;
    logic                  r_neg_a;
    logic                  r_neg_b;
    logic                  r_div0;
    logic                  r_ovf;
    logic [XLEN-1:0]       r_opa;
    logic [2*XLEN-1:0]     r_acc;
    logic [2*XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]       r_mplier;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_quo;
    logic [XLEN-1:0]       r_dvsr;

    // Launch decode
    logic                  w_launch;
    logic                  w_a_signed;
    logic                  w_b_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [XLEN-1:0]       w_a_mag;
    logic [XLEN-1:0]       w_b_mag;
    logic                  w_div0;
    logic                  w_ovf;

    // One iteration of each algorithm
    logic [2*XLEN-1:0]     w_acc_nxt;
    logic [XLEN:0]         w_rem_sh;
    logic [XLEN-1:0]       w_diff;
    logic                  w_sub_ok;
    logic [XLEN-1:0]       w_rem_nxt;
    logic [XLEN-1:0]       w_quo_nxt;

    // Sign-corrected results and final selection
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_quo_s;
    logic [XLEN-1:0]       w_rem_s;
    logic [XLEN-1:0]       w_final;

    assign w_launch   = (r_state == S_IDLE) && start && !flush;

    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    assign w_a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_a_neg    = w_a_signed && opA[XLEN-1];
    assign w_b_neg    = w_b_signed && opB[XLEN-1];
    // INT_MIN negates to itself, which is its correct unsigned magnitude
    assign w_a_mag    = w_a_neg ? -opA : opA;
    assign w_b_mag    = w_b_neg ? -opB : opB;

    assign w_div0     = op[2] && (opB == '0);
    // Only DIV (4) and REM (6) can overflow; both have op[0] clear
    assign w_ovf      = op[2] && !op[0] && (opA == INT_MIN) && (opB == '1);

    // Shift-add multiply step: add the shifted multiplicand when the multiplier LSB is set
    assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Restoring divide step: the partial remainder is always below the divisor,
    // so the XLEN-bit difference is exact whenever the subtraction is kept
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_sub_ok   = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_diff     = w_rem_sh[XLEN-1:0] - r_dvsr;
    assign w_rem_nxt  = w_sub_ok ? w_diff : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt  = {r_quo[XLEN-2:0], w_sub_ok};

    // Unsigned ops never set the neg flags, so these are pass-throughs for them
    assign w_prod     = (r_neg_a ^ r_neg_b) ? -w_acc_nxt : w_acc_nxt;
    assign w_quo_s    = (r_neg_a ^ r_neg_b) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_s    = r_neg_a ? -w_rem_nxt : w_rem_nxt;

    // Select the result written at the BUSY->DONE edge, with special-case overrides
    always_comb begin
        w_final = '0;
        case (r_op)
            3'd0:             w_final = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_final = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: begin
                if (r_div0)     w_final = '1;
                else if (r_ovf) w_final = INT_MIN;
                else            w_final = w_quo_s;
            end
            default: begin
                if (r_div0)     w_final = r_opa;
                else if (r_ovf) w_final = '0;
                else            w_final = w_rem_s;
            end
        endcase
    end

    // FSM, iteration counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_BUSY;
                        r_cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state  <= S_DONE;
                        r_result <= w_final;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // start still belongs to the completing op here, so never relaunch
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand latch at launch, then one multiply and one divide iteration per BUSY cycle
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_op     <= op;
            r_neg_a  <= w_a_neg;
            r_neg_b  <= w_b_neg;
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_opa    <= opA;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_dvsr   <= w_b_mag;
        end else if (r_state == S_BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
        end
    end

    assign busy   = (r_state == S_BUSY);
    assign done   = (r_state == S_DONE);
    assign stall  = w_launch || (r_state == S_BUSY);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, reference model for
// random vectors, and hand-written flush / reset / back-to-back sequences.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_asrt = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    logic [31:0] last_exp = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] e);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp = e;
        return v;
    endfunction

    // Independent arithmetic model built on the simulator's 64-bit math
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] x, y, p;
        logic signed [31:0] sa, sbv;
        logic               ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin x = {32'h0, a}; y = {32'h0, b}; p = x * y; return p[31:0]; end
            3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
            3'd2: begin x = {{32{a[31]}}, a}; y = {32'h0, b}; p = x * y; return p[63:32]; end
            3'd3: begin x = {32'h0, a}; y = {32'h0, b}; p = x * y; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sbv);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called just after a rising edge; that cycle is C0. Returns just after the
    // edge that ends the DONE cycle, i.e. in C34.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input bit keep_start);
        int          stall_cnt;
        bit          got;
        logic [31:0] exp_v;
        op = o; opA = a; opB = b; start = 1'b1;
        sb.push_back(e);
        stall_cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (c >= 1 && c <= 32) check("busy_during_op", busy, 1'b1);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
                check("latency", c, 33);
                check("stall_in_done", stall, 1'b0);
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    exp_v = sb.pop_front();
                    check($sformatf("result op%0d %h,%h", o, a, b), result, exp_v);
                end
            end
            @(posedge clk); #1;
            // Operands change mid-op; the latched copy must be used
            if (c == 5) begin opA = ~a; opB = b + 32'd1; op = o ^ 3'd1; end
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        check("stall_cycles", stall_cnt, 33);
        if (!keep_start) start = 1'b0;
        last_exp = e;
    endtask

    initial begin
        int          d1, d2, dcount;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs.push_back(mk(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB));
        vecs.push_back(mk(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000));
        vecs.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
        vecs.push_back(mk(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        vecs.push_back(mk(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD));
        vecs.push_back(mk(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF));
        vecs.push_back(mk(3'd5, 32'd100,       32'd7,         32'd14));
        vecs.push_back(mk(3'd7, 32'd100,       32'd7,         32'd2));
        vecs.push_back(mk(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF));
        vecs.push_back(mk(3'd7, 32'd5,         32'd0,         32'd5));
        vecs.push_back(mk(3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB));
        vecs.push_back(mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
        vecs.push_back(mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk(3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF));
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) ra = -ra;
            vecs.push_back(mk(ro, ra, rb, ref_model(ro, ra, rb)));
        end

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = 3'd0; opA = 32'h0; opB = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_stall", stall, 1'b0);
        check("reset_result", result, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
        @(negedge clk);
        check("done_single_pulse", done, 1'b0);
        check("result_held", result, last_exp);

        // Flush in C10 of a DIVU: no done, result unchanged, then a clean MUL
        @(posedge clk); #1;
        op = 3'd5; opA = 32'd100; opB = 32'd7; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 1'b0);
        check("flush_stall", stall, 1'b0);
        check("flush_done", done, 1'b0);
        check("flush_result", result, last_exp);
        dcount = 0;
        repeat (40) begin @(negedge clk); if (done) dcount++; end
        check("flush_no_done", dcount, 0);
        @(posedge clk); #1;
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

        // Asynchronous reset in C20 of an op
        op = 3'd4; opA = 32'd1000; opB = 32'd3; start = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0; start = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back with start held: done pulses 34 cycles apart
        run_op(3'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 1'b1);
        d1 = done_cyc;
        run_op(3'd7, 32'd1000, 32'd33, 32'd10, 1'b0);
        d2 = done_cyc;
        check("b2b_done_spacing", d2 - d1, 34);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
